// File: rtl/cpu_cu_if.sv
// Control bundle between the multi-cycle control unit and the execution unit.
// The control unit owns the master side; the execution unit takes the slave side.
interface cpu_cu_if;
    logic [15:0] IR;
    logic [2:0]  ALU_Status;
    logic        rw_en;
    logic        s_sel;
    logic        adr_sel;
    logic        ir_ld;
    logic        pc_ld;
    logic        pc_inc;
    logic        pc_sel;
    logic [2:0]  W_Adr;
    logic [2:0]  R_Adr;
    logic [2:0]  S_Adr;
    logic [3:0]  Alu_Op;
    logic        mem_we;
    logic [2:0]  flags;
    logic        halted;
    logic        inst_done;

    modport master (
        input  IR, ALU_Status,
        output rw_en, s_sel, adr_sel, ir_ld, pc_ld, pc_inc, pc_sel,
        output W_Adr, R_Adr, S_Adr, Alu_Op, mem_we, flags, halted, inst_done
    );

    modport slave (
        output IR, ALU_Status,
        input  rw_en, s_sel, adr_sel, ir_ld, pc_ld, pc_inc, pc_sel,
        input  W_Adr, R_Adr, S_Adr, Alu_Op, mem_we, flags, halted, inst_done
    );
endinterface

// File: rtl/cpu_cu.sv
// Multi-cycle Moore control unit for the 16-bit CPU.
// Runs FETCH -> DECODE -> EXECUTE and keeps a latched flag copy for branches.
module cpu_cu #(
    parameter logic [3:0] ALU_PASS_R = 4'h0,
    parameter logic [3:0] ALU_PASS_S = 4'h1
) (
    input logic      clk,
    input logic      reset,
    cpu_cu_if.master bus
);

    typedef enum logic [3:0] {
        RST, FETCH, DECODE, EX_ALU, EX_LD, EX_ST, EX_BR, EX_JMP, HALT
    } state_t;

    state_t     state;
    state_t     nxt;
    logic [2:0] flags_q;
    logic       br_take;

    wire [1:0] cls = bus.IR[15:14];
    wire       sub = bus.IR[13];

    assign bus.W_Adr = bus.IR[8:6];
    assign bus.R_Adr = bus.IR[5:3];
    assign bus.S_Adr = bus.IR[2:0];
    assign bus.flags = flags_q;

    // Latched flags are {N,Z,C}
    always_comb begin
        br_take = 1'b0;
        unique case (bus.IR[13:11])
            3'b000:  br_take = 1'b1;
            3'b001:  br_take = flags_q[1];
            3'b010:  br_take = !flags_q[1];
            3'b011:  br_take = flags_q[0];
            3'b100:  br_take = !flags_q[0];
            3'b101:  br_take = flags_q[2];
            3'b110:  br_take = !flags_q[2];
            default: br_take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RST;
            flags_q <= 3'b000;
        end else begin
            state <= nxt;
            if (state == EX_ALU)
                flags_q <= bus.ALU_Status;
        end
    end

    always_comb begin
        nxt           = state;
        bus.rw_en     = 1'b0;
        bus.s_sel     = 1'b0;
        bus.adr_sel   = 1'b0;
        bus.ir_ld     = 1'b0;
        bus.pc_ld     = 1'b0;
        bus.pc_inc    = 1'b0;
        bus.pc_sel    = 1'b0;
        bus.Alu_Op    = ALU_PASS_R;
        bus.mem_we    = 1'b0;
        bus.halted    = 1'b0;
        bus.inst_done = 1'b0;
        unique case (state)
            RST: nxt = FETCH;
            FETCH: begin
                bus.ir_ld  = 1'b1;
                bus.pc_inc = 1'b1;
                nxt        = DECODE;
            end
            DECODE: begin
                unique case (1'b1)
                    cls == 2'b00:         nxt = EX_ALU;
                    cls == 2'b01:         nxt = EX_BR;
                    cls == 2'b10 && !sub: nxt = EX_LD;
                    cls == 2'b10 && sub:  nxt = EX_ST;
                    cls == 2'b11 && !sub: nxt = EX_JMP;
                    cls == 2'b11 && sub:  nxt = HALT;
                    default:              nxt = RST;
                endcase
            end
            EX_ALU: begin
                bus.Alu_Op    = bus.IR[13:10];
                bus.rw_en     = 1'b1;
                bus.inst_done = 1'b1;
                nxt           = FETCH;
            end
            EX_LD: begin
                bus.adr_sel   = 1'b1;
                bus.s_sel     = 1'b1;
                bus.Alu_Op    = ALU_PASS_S;
                bus.rw_en     = 1'b1;
                bus.inst_done = 1'b1;
                nxt           = FETCH;
            end
            EX_ST: begin
                bus.adr_sel   = 1'b1;
                bus.Alu_Op    = ALU_PASS_S;
                bus.mem_we    = 1'b1;
                bus.inst_done = 1'b1;
                nxt           = FETCH;
            end
            EX_BR: begin
                bus.pc_ld     = br_take;
                bus.inst_done = 1'b1;
                nxt           = FETCH;
            end
            EX_JMP: begin
                bus.pc_sel    = 1'b1;
                bus.pc_ld     = 1'b1;
                bus.inst_done = 1'b1;
                nxt           = FETCH;
            end
            HALT: bus.halted = 1'b1;
            default: nxt = RST;
        endcase
    end

endmodule

// File: tb/tb_cpu_cu.sv
// Directed bench for cpu_cu: walks each instruction class through
// FETCH/DECODE/EXECUTE and checks strobes, addresses and latched flags.
module tb_cpu_cu;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    cpu_cu_if bus ();

    cpu_cu #(.ALU_PASS_R(4'h0), .ALU_PASS_S(4'h1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {rw_en,s_sel,adr_sel,ir_ld,pc_ld,pc_inc,pc_sel,mem_we,halted,inst_done}
    localparam logic [9:0] S_IDLE = 10'b0000000000;
    localparam logic [9:0] S_FET  = 10'b0001010000;
    localparam logic [9:0] S_ALU  = 10'b1000000001;
    localparam logic [9:0] S_LD   = 10'b1110000001;
    localparam logic [9:0] S_ST   = 10'b0010000101;
    localparam logic [9:0] S_BRT  = 10'b0000100001;
    localparam logic [9:0] S_BRN  = 10'b0000000001;
    localparam logic [9:0] S_JMP  = 10'b0000101001;
    localparam logic [9:0] S_HLT  = 10'b0000000010;

    function automatic logic [9:0] strobes();
        return {bus.rw_en, bus.s_sel, bus.adr_sel, bus.ir_ld, bus.pc_ld,
                bus.pc_inc, bus.pc_sel, bus.mem_we, bus.halted, bus.inst_done};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is in FETCH; leaves the bench in EXECUTE.
    task automatic to_exec(input logic [15:0] ir, input logic [2:0] st,
                           input string tag);
        bus.IR         = ir;
        bus.ALU_Status = st;
        check({tag, " fetch"}, {6'd0, strobes()}, {6'd0, S_FET});
        tick();
        check({tag, " decode"}, {6'd0, strobes()}, {6'd0, S_IDLE});
        tick();
    endtask

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        reset          = 1'b0;
        bus.IR         = 16'h0000;
        bus.ALU_Status = 3'b000;
        repeat (2) tick();
        check("reset strobes", {6'd0, strobes()}, {6'd0, S_IDLE});
        check("reset flags", {13'd0, bus.flags}, 16'h0000);

        reset = 1'b1;
        tick();

        to_exec(16'h14CA, 3'b010, "alu");
        check("alu strobes", {6'd0, strobes()}, {6'd0, S_ALU});
        check("alu op", {12'd0, bus.Alu_Op}, 16'h0005);
        check("alu wrs", {7'd0, bus.W_Adr, bus.R_Adr, bus.S_Adr}, {7'd0, 9'o312});
        tick();
        check("alu flags", {13'd0, bus.flags}, 16'h0002);

        // Abort an ALU instruction mid-execute with an asynchronous reset
        to_exec(16'h14CA, 3'b111, "abort");
        reset = 1'b0;
        #1;
        check("abort strobes", {6'd0, strobes()}, {6'd0, S_IDLE});
        check("abort flags", {13'd0, bus.flags}, 16'h0000);
        tick();
        reset = 1'b1;
        tick();
        check("rel fetch", {6'd0, strobes()}, {6'd0, S_FET});

        to_exec(16'h0000, 3'b100, "alu2");
        check("alu2 op", {12'd0, bus.Alu_Op}, 16'h0000);
        tick();
        check("alu2 flags", {13'd0, bus.flags}, 16'h0004);

        to_exec(16'h8110, 3'b011, "ld");
        check("ld strobes", {6'd0, strobes()}, {6'd0, S_LD});
        check("ld op", {12'd0, bus.Alu_Op}, 16'h0001);
        check("ld w", {13'd0, bus.W_Adr}, 16'h0004);
        check("ld r", {13'd0, bus.R_Adr}, 16'h0002);
        tick();
        check("ld flags", {13'd0, bus.flags}, 16'h0004);

        to_exec(16'hA015, 3'b011, "st");
        check("st strobes", {6'd0, strobes()}, {6'd0, S_ST});
        check("st op", {12'd0, bus.Alu_Op}, 16'h0001);
        check("st r", {13'd0, bus.R_Adr}, 16'h0002);
        check("st s", {13'd0, bus.S_Adr}, 16'h0005);
        tick();
        check("st flags", {13'd0, bus.flags}, 16'h0004);

        // Live status says Z=1 but latched Z=0: must not branch
        to_exec(16'h48FC, 3'b010, "beq nz");
        check("beq nz strobes", {6'd0, strobes()}, {6'd0, S_BRN});
        tick();

        to_exec(16'h14CA, 3'b010, "alu z");
        tick();
        to_exec(16'h48FC, 3'b000, "beq z");
        check("beq z strobes", {6'd0, strobes()}, {6'd0, S_BRT});
        tick();

        to_exec(16'h7800, 3'b111, "never");
        check("never strobes", {6'd0, strobes()}, {6'd0, S_BRN});
        tick();

        to_exec(16'h4000, 3'b000, "always");
        check("always strobes", {6'd0, strobes()}, {6'd0, S_BRT});
        tick();

        to_exec(16'h5000, 3'b000, "bne");
        check("bne strobes", {6'd0, strobes()}, {6'd0, S_BRN});
        tick();

        to_exec(16'hC010, 3'b101, "jmp");
        check("jmp strobes", {6'd0, strobes()}, {6'd0, S_JMP});
        check("jmp op", {12'd0, bus.Alu_Op}, 16'h0000);
        check("jmp r", {13'd0, bus.R_Adr}, 16'h0002);
        tick();
        check("jmp flags", {13'd0, bus.flags}, 16'h0002);

        to_exec(16'hE000, 3'b000, "halt");
        for (int i = 0; i < 20; i++) begin
            check("halt strobes", {6'd0, strobes()}, {6'd0, S_HLT});
            tick();
        end

        reset = 1'b0;
        #1;
        check("halt reset", {6'd0, strobes()}, {6'd0, S_IDLE});
        tick();
        reset = 1'b1;
        tick();
        check("post halt fetch", {6'd0, strobes()}, {6'd0, S_FET});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
